// File: rtl/multi_ball_pkg.sv
// Shared widths, wall-flag bit positions, FSM encoding and the reset-position
// helper for the multi-ball motion engine.
package multi_ball_pkg;

   localparam int COORD_W = 10;   // screen coordinate width
   localparam int STEP_W  = 4;    // per-ball step / half-size width
   localparam int CALC_W  = 11;   // bound arithmetic width, wide enough to never wrap

   localparam int FLAG_LEFT   = 0;
   localparam int FLAG_RIGHT  = 1;
   localparam int FLAG_TOP    = 2;
   localparam int FLAG_BOTTOM = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Balls start evenly spread across the screen width.
   function automatic logic [COORD_W-1:0] reset_x(input int idx, input int n_balls, input int x_max);
      return COORD_W'((idx + 1) * (x_max + 1) / (n_balls + 1));
   endfunction

endpackage

// File: rtl/ball_axis_step.sv
// Single-axis bounce step: given position, direction, step and half-size,
// produce the next position/direction and which bound (if any) was hit.
// Purely combinational; the engine shares one instance per axis across balls.
module ball_axis_step
   import multi_ball_pkg::*;
#(
   parameter int MIN_P = 0,
   parameter int MAX_P = 639
) (
   input  logic [COORD_W-1:0] pos_i,
   input  logic               dir_i,     // 1 = increasing coordinate
   input  logic [STEP_W:0]    step_i,    // one bit wider to carry a gravity speed of 16
   input  logic [STEP_W-1:0]  size_i,    // effective half-size (never zero)
   output logic [COORD_W-1:0] pos_o,
   output logic               dir_o,
   output logic               hit_lo_o,
   output logic               hit_hi_o
);

   localparam logic [CALC_W-1:0] MIN_C = CALC_W'(MIN_P);
   localparam logic [CALC_W-1:0] MAX_C = CALC_W'(MAX_P);

   logic [CALC_W-1:0] pos_c;
   logic [CALC_W-1:0] step_c;
   logic [CALC_W-1:0] size_c;
   logic [CALC_W-1:0] lo_pos_c;
   logic [CALC_W-1:0] hi_pos_c;

   assign pos_c    = CALC_W'(pos_i);
   assign step_c   = CALC_W'(step_i);
   assign size_c   = CALC_W'(size_i);
   assign lo_pos_c = MIN_C + size_c;
   assign hi_pos_c = MAX_C - size_c;

   // Out-of-bounds override first (size may have grown), then normal motion.
   always_comb begin
      pos_o    = pos_i;
      dir_o    = dir_i;
      hit_lo_o = 1'b0;
      hit_hi_o = 1'b0;
      if (pos_c + size_c > MAX_C) begin
         pos_o    = COORD_W'(hi_pos_c);
         dir_o    = 1'b0;
         hit_hi_o = 1'b1;
      end else if (pos_c < lo_pos_c) begin
         pos_o    = COORD_W'(lo_pos_c);
         dir_o    = 1'b1;
         hit_lo_o = 1'b1;
      end else if (dir_i) begin
         if (pos_c + step_c + size_c >= MAX_C) begin
            pos_o    = COORD_W'(hi_pos_c);
            dir_o    = 1'b0;
            hit_hi_o = 1'b1;
         end else begin
            pos_o = COORD_W'(pos_c + step_c);
         end
      end else begin
         if (pos_c <= lo_pos_c + step_c) begin
            pos_o    = COORD_W'(lo_pos_c);
            dir_o    = 1'b1;
            hit_lo_o = 1'b1;
         end else begin
            pos_o = COORD_W'(pos_c - step_c);
         end
      end
   end

endmodule

// File: rtl/multi_ball_engine.sv
// Multi-ball motion engine. On each synchronised vsync falling edge (when
// enabled and idle) it walks every ball once, one ball per cycle, through a
// shared pair of axis-step units, then pulses frame_done.
// Optional build macro: GRAVITY_EN (signed vertical velocity per ball).
module multi_ball_engine
   import multi_ball_pkg::*;
#(
   parameter int N_BALLS = 2,
   parameter int X_MIN   = 0,
   parameter int X_MAX   = 639,
   parameter int Y_MIN   = 0,
   parameter int Y_MAX   = 479,
   parameter int GRAVITY = 1,
   parameter int VY_MAX  = 15
) (
   input  logic                          clk_in,
   input  logic                          rst_n,
   input  logic                          vsync_in,
   input  logic                          enable,
   input  logic [STEP_W*N_BALLS-1:0]     x_step_in,
   input  logic [STEP_W*N_BALLS-1:0]     y_step_in,
   input  logic [STEP_W*N_BALLS-1:0]     size_in,
   output logic [COORD_W*N_BALLS-1:0]    ball_x_out,
   output logic [COORD_W*N_BALLS-1:0]    ball_y_out,
   output logic [COORD_W*N_BALLS-1:0]    ball_s_out,
   output logic [4*N_BALLS-1:0]          wall_flags,
   output logic                          frame_done
);

   localparam int                 IDX_W    = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_BALLS - 1);
   localparam logic [COORD_W-1:0] Y_RST    = COORD_W'((Y_MAX + 1) / 2);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               upd_en;
   logic               vs_meta_q, vs_sync_q, vs_prev_q;
   logic               start;

   logic [N_BALLS-1:0] xdir_all;
   logic [COORD_W-1:0] cur_x, cur_y;
   logic               cur_xdir, cur_ydir;
   logic [STEP_W-1:0]  cur_xstep, cur_ystep, cur_size, eff_size;
   logic [STEP_W:0]    y_step_eff;
   logic [COORD_W-1:0] x_new, y_new;
   logic               xdir_new, ydir_new;
   logic               x_hit_lo, x_hit_hi, y_hit_lo, y_hit_hi;
   logic [3:0]         flags_new;

`ifdef GRAVITY_EN
   logic [5*N_BALLS-1:0] vy_all;
   logic signed [4:0]    cur_vy, vy_acc, vy_new;
   logic signed [6:0]    vy_sum;
`else
   logic [N_BALLS-1:0]   ydir_all;
   logic [31:0]          unused_cfg;
   assign unused_cfg = 32'(GRAVITY) ^ 32'(VY_MAX);
`endif

   // Two-flop synchroniser plus edge history for the active-low vsync.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         vs_meta_q <= 1'b1;
         vs_sync_q <= 1'b1;
         vs_prev_q <= 1'b1;
      end else begin
         vs_meta_q <= vsync_in;
         vs_sync_q <= vs_meta_q;
         vs_prev_q <= vs_sync_q;
      end
   end

   assign start = vs_prev_q & ~vs_sync_q;

   // FSM state and ball index registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic: starts are dropped unless idle and enabled.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      upd_en     = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && enable) begin
               state_d = ST_UPDATE;
               idx_d   = '0;
            end
         end
         ST_UPDATE: begin
            upd_en = 1'b1;
            if (idx_q == IDX_LAST) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Select the current ball's state and live step/size inputs.
   always_comb begin
      cur_x     = '0;
      cur_y     = '0;
      cur_xdir  = 1'b0;
      cur_ydir  = 1'b0;
      cur_xstep = '0;
      cur_ystep = '0;
      cur_size  = '0;
`ifdef GRAVITY_EN
      cur_vy    = '0;
`endif
      for (int i = 0; i < N_BALLS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_x     = ball_x_out[COORD_W*i +: COORD_W];
            cur_y     = ball_y_out[COORD_W*i +: COORD_W];
            cur_xdir  = xdir_all[i];
            cur_xstep = x_step_in[STEP_W*i +: STEP_W];
            cur_ystep = y_step_in[STEP_W*i +: STEP_W];
            cur_size  = size_in[STEP_W*i +: STEP_W];
`ifdef GRAVITY_EN
            cur_vy    = $signed(vy_all[5*i +: 5]);
`else
            cur_ydir  = ydir_all[i];
`endif
         end
      end
   end

   assign eff_size = (cur_size == '0) ? STEP_W'(1) : cur_size;

`ifdef GRAVITY_EN
   // Accelerate, cap at the downward ceiling, and turn speed into magnitude/direction.
   always_comb begin
      vy_sum     = 7'(cur_vy) + 7'(GRAVITY);
      vy_acc     = (vy_sum > 7'(VY_MAX)) ? 5'(VY_MAX) : 5'(vy_sum);
      cur_ydir   = ~vy_acc[4];
      y_step_eff = vy_acc[4] ? 5'(-vy_acc) : 5'(vy_acc);
      vy_new     = vy_acc;
      if (y_hit_hi) begin
         vy_new = -$signed({1'b0, cur_ystep});
      end else if (y_hit_lo) begin
         vy_new = '0;
      end
   end
`else
   assign y_step_eff = {1'b0, cur_ystep};
`endif

   ball_axis_step #(.MIN_P(X_MIN), .MAX_P(X_MAX)) u_axis_x (
      .pos_i    (cur_x),
      .dir_i    (cur_xdir),
      .step_i   ({1'b0, cur_xstep}),
      .size_i   (eff_size),
      .pos_o    (x_new),
      .dir_o    (xdir_new),
      .hit_lo_o (x_hit_lo),
      .hit_hi_o (x_hit_hi)
   );

   ball_axis_step #(.MIN_P(Y_MIN), .MAX_P(Y_MAX)) u_axis_y (
      .pos_i    (cur_y),
      .dir_i    (cur_ydir),
      .step_i   (y_step_eff),
      .size_i   (eff_size),
      .pos_o    (y_new),
      .dir_o    (ydir_new),
      .hit_lo_o (y_hit_lo),
      .hit_hi_o (y_hit_hi)
   );

   // Pack axis hits into the per-ball wall flag layout.
   always_comb begin
      flags_new              = '0;
      flags_new[FLAG_LEFT]   = x_hit_lo;
      flags_new[FLAG_RIGHT]  = x_hit_hi;
      flags_new[FLAG_TOP]    = y_hit_lo;
      flags_new[FLAG_BOTTOM] = y_hit_hi;
   end

   for (genvar gi = 0; gi < N_BALLS; gi++) begin : g_ball
      localparam logic [COORD_W-1:0] X_RST = reset_x(gi, N_BALLS, X_MAX);

      logic [COORD_W-1:0] x_q, y_q;
      logic [STEP_W-1:0]  s_q;
      logic [3:0]         flags_q;
      logic               xdir_q;
      logic               sel;

      assign sel = upd_en && (idx_q == IDX_W'(gi));

      // Per-ball state, rewritten only in the cycle this ball is processed.
      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            x_q     <= X_RST;
            y_q     <= Y_RST;
            s_q     <= STEP_W'(1);
            flags_q <= '0;
            xdir_q  <= ((gi % 2) == 0);
         end else if (sel) begin
            x_q     <= x_new;
            y_q     <= y_new;
            s_q     <= eff_size;
            flags_q <= flags_new;
            xdir_q  <= xdir_new;
         end
      end

`ifdef GRAVITY_EN
      logic signed [4:0] vy_q;

      // Vertical velocity replaces the direction bit.
      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            vy_q <= '0;
         end else if (sel) begin
            vy_q <= vy_new;
         end
      end

      assign vy_all[5*gi +: 5] = vy_q;
`else
      logic ydir_q;

      // Vertical direction: starts moving down.
      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            ydir_q <= 1'b1;
         end else if (sel) begin
            ydir_q <= ydir_new;
         end
      end

      assign ydir_all[gi] = ydir_q;
`endif

      assign xdir_all[gi]                        = xdir_q;
      assign ball_x_out[COORD_W*gi +: COORD_W]   = x_q;
      assign ball_y_out[COORD_W*gi +: COORD_W]   = y_q;
      assign ball_s_out[COORD_W*gi +: COORD_W]   = {{(COORD_W-STEP_W){1'b0}}, s_q};
      assign wall_flags[4*gi +: 4]               = flags_q;
   end

endmodule
